// File: rtl/hazard_ctrl.sv
// Pipeline sequencing for the five-stage core: load-use interlock, EX redirect flush,
// multi-cycle mul/div occupancy of EX, data-memory wait states and a stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned MD_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_md_valid,
  input  logic        ex_redirect,
  input  logic        dmem_wait,
  input  logic        perf_clr,
  output logic        pc_stop,
  output logic        if_id_stop,
  output logic        if_id_flush,
  output logic        id_ex_stop,
  output logic        id_ex_flush,
  output logic        ex_mem_stop,
  output logic        ex_mem_flush,
  output logic        md_busy,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StMdWait = 2'd1,
    StMdDone = 2'd2
  } state_e;

  // The RUN cycle that accepts the mul/div and the release cycle are not counted here.
  localparam logic [5:0] MdLoad = 6'(MD_CYCLES - 2);

  state_e      state_q, state_d;
  logic [5:0]  md_cnt_q, md_cnt_d;
  logic [31:0] stall_q, stall_d;
  logic        load_use;
  logic        md_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      md_cnt_q <= 6'd0;
      stall_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      stall_q  <= stall_d;
    end
  end

  // A memory wait freezes the sequencer entirely; only the perf counter keeps moving.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    if (!dmem_wait) begin
      unique case (state_q)
        StRun: begin
          if (ex_md_valid) begin
            state_d  = StMdWait;
            md_cnt_d = MdLoad;
          end
        end
        StMdWait: begin
          if (md_cnt_q == 6'd1) begin
            state_d = StMdDone;
          end else begin
            md_cnt_d = md_cnt_q - 6'd1;
          end
        end
        StMdDone: state_d = StRun;
        default:  state_d = StRun;
      endcase
    end
  end

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  assign md_stall = ((state_q == StRun) && ex_md_valid) || (state_q == StMdWait);

  always_comb begin
    pc_stop      = 1'b0;
    if_id_stop   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stop   = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stop  = 1'b0;
    ex_mem_flush = 1'b0;
    if (rst_n) begin
      if (dmem_wait) begin
        pc_stop     = 1'b1;
        if_id_stop  = 1'b1;
        id_ex_stop  = 1'b1;
        ex_mem_stop = 1'b1;
      end else if (md_stall) begin
        pc_stop      = 1'b1;
        if_id_stop   = 1'b1;
        id_ex_stop   = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (ex_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_stop     = 1'b1;
        if_id_stop  = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (perf_clr) begin
      stall_d = 32'd0;
    end else if (pc_stop) begin
      stall_d = stall_q + 32'd1;
    end
  end

  assign md_busy      = rst_n && (state_q == StMdWait);
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic,
// compared against a mul/div "age" reference model.
module tb_hazard_ctrl;

  localparam int unsigned MdCycles = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_used, id_rs2_used, ex_mem_read, ex_md_valid, ex_redirect;
  logic        dmem_wait, perf_clr;
  logic        pc_stop, if_id_stop, if_id_flush, id_ex_stop, id_ex_flush;
  logic        ex_mem_stop, ex_mem_flush, md_busy;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_CYCLES(MdCycles)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .ex_md_valid  (ex_md_valid),
    .ex_redirect  (ex_redirect),
    .dmem_wait    (dmem_wait),
    .perf_clr     (perf_clr),
    .pc_stop      (pc_stop),
    .if_id_stop   (if_id_stop),
    .if_id_flush  (if_id_flush),
    .id_ex_stop   (id_ex_stop),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_stop  (ex_mem_stop),
    .ex_mem_flush (ex_mem_flush),
    .md_busy      (md_busy),
    .stall_cycles (stall_cycles)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: m_age = unfrozen cycles the current mul/div has spent in EX (-1: none).
  int          m_age;
  logic [31:0] m_stall;

  logic s_pc_stop, s_if_id_stop, s_if_id_flush, s_id_ex_stop, s_id_ex_flush;
  logic s_ex_mem_stop, s_ex_mem_flush, s_md_busy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_mem_read = 1'b0; ex_rd = 5'd0; ex_md_valid = 1'b0; ex_redirect = 1'b0;
    dmem_wait = 1'b0; perf_clr = 1'b0;
  endtask

  // Checks one cycle against the model at the negedge, then advances the model at the posedge.
  task automatic tick();
    logic e_pc, e_ifs, e_iff, e_ids, e_idf, e_exs, e_exf, lu, md_rel, md_stall;
    @(negedge clk);
    {e_pc, e_ifs, e_iff, e_ids, e_idf, e_exs, e_exf} = '0;
    md_rel   = (m_age == int'(MdCycles) - 1);
    md_stall = (m_age >= 1 && !md_rel) || (m_age < 0 && ex_md_valid);
    lu = ex_mem_read && ex_rd != 0 &&
         ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    if (rst_n) begin
      if (dmem_wait)        {e_pc, e_ifs, e_ids, e_exs} = 4'hf;
      else if (md_stall)    {e_pc, e_ifs, e_ids, e_exf} = 4'hf;
      else if (ex_redirect) {e_iff, e_idf} = 2'b11;
      else if (lu)          {e_pc, e_ifs, e_idf} = 3'b111;
    end
    s_pc_stop = pc_stop;         s_if_id_stop = if_id_stop;   s_if_id_flush = if_id_flush;
    s_id_ex_stop = id_ex_stop;   s_id_ex_flush = id_ex_flush; s_ex_mem_stop = ex_mem_stop;
    s_ex_mem_flush = ex_mem_flush; s_md_busy = md_busy;
    check_eq("pc_stop", 32'(pc_stop), 32'(e_pc));
    check_eq("if_id_stop", 32'(if_id_stop), 32'(e_ifs));
    check_eq("if_id_flush", 32'(if_id_flush), 32'(e_iff));
    check_eq("id_ex_stop", 32'(id_ex_stop), 32'(e_ids));
    check_eq("id_ex_flush", 32'(id_ex_flush), 32'(e_idf));
    check_eq("ex_mem_stop", 32'(ex_mem_stop), 32'(e_exs));
    check_eq("ex_mem_flush", 32'(ex_mem_flush), 32'(e_exf));
    check_eq("md_busy", 32'(md_busy),
             32'(rst_n && m_age >= 1 && m_age <= int'(MdCycles) - 2));
    check_eq("stall_cycles", stall_cycles, m_stall);
    @(posedge clk);
    if (!rst_n) begin
      m_age   = -1;
      m_stall = 32'd0;
    end else begin
      if (perf_clr) m_stall = 32'd0;
      else if (e_pc) m_stall = m_stall + 32'd1;
      if (!dmem_wait) begin
        if (md_rel) m_age = -1;
        else if (m_age >= 1) m_age = m_age + 1;
        else if (ex_md_valid) m_age = 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n   = 1'b0;
    m_age   = -1;
    m_stall = 32'd0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    m_age   = -1;
    m_stall = 32'd0;
    idle_inputs();
    rst_n = 1'b0;
    #2;
    check_eq("reset_pc_stop", 32'(pc_stop), 32'd0);
    check_eq("reset_stall_cycles", stall_cycles, 32'd0);
    do_reset();

    // Load-use through rs2
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
    tick();
    check_eq("lu_pc_stop", 32'(s_pc_stop), 32'd1);
    check_eq("lu_if_id_stop", 32'(s_if_id_stop), 32'd1);
    check_eq("lu_id_ex_flush", 32'(s_id_ex_flush), 32'd1);
    idle_inputs();
    tick();
    check_eq("lu_one_cycle", 32'(s_pc_stop), 32'd0);
    check_eq("lu_stall_cnt", stall_cycles, 32'd1);

    // x0 and unused operand never stall
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
    tick();
    check_eq("x0_no_stall", 32'(s_pc_stop), 32'd0);
    ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1'b0;
    tick();
    check_eq("unused_no_stall", 32'(s_pc_stop), 32'd0);

    // Mul/div held high from cycle 0
    do_reset();
    ex_md_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check_eq($sformatf("md_stall_c%0d", c), 32'(s_pc_stop), 32'(c <= 6));
      check_eq($sformatf("md_flush_c%0d", c), 32'(s_ex_mem_flush), 32'(c <= 6));
      check_eq($sformatf("md_busy_c%0d", c), 32'(s_md_busy), 32'(c >= 1 && c <= 6));
    end
    ex_md_valid = 1'b0;
    tick();
    check_eq("md_no_retrigger", 32'(s_pc_stop), 32'd0);
    check_eq("md_stall_cnt", stall_cycles, 32'd7);

    // Mul/div with a 3-cycle memory wait starting in cycle 2
    do_reset();
    ex_md_valid = 1'b1;
    for (int c = 0; c < 11; c++) begin
      dmem_wait = (c >= 2 && c <= 4);
      tick();
      check_eq($sformatf("mdw_stall_c%0d", c), 32'(s_pc_stop), 32'(c <= 9));
      check_eq($sformatf("mdw_flush_c%0d", c), 32'(s_ex_mem_flush),
               32'(c <= 9 && !(c >= 2 && c <= 4)));
    end
    idle_inputs();
    tick();

    // Redirect together with load-use
    ex_redirect = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_rs1_used = 1'b1;
    tick();
    check_eq("rdlu_if_id_flush", 32'(s_if_id_flush), 32'd1);
    check_eq("rdlu_id_ex_flush", 32'(s_id_ex_flush), 32'd1);
    check_eq("rdlu_pc_stop", 32'(s_pc_stop), 32'd0);
    check_eq("rdlu_if_id_stop", 32'(s_if_id_stop), 32'd0);

    // perf_clr during a stall cycle
    ex_redirect = 1'b0; perf_clr = 1'b1;
    tick();
    idle_inputs();
    check_eq("perf_clr", stall_cycles, 32'd0);

    // Reset asserted in MD_WAIT
    ex_md_valid = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    rst_n = 1'b0;
    m_age = -1;
    m_stall = 32'd0;
    #1;
    check_eq("rst_mid_pc_stop", 32'(pc_stop), 32'd0);
    check_eq("rst_mid_if_id_stop", 32'(if_id_stop), 32'd0);
    check_eq("rst_mid_id_ex_stop", 32'(id_ex_stop), 32'd0);
    check_eq("rst_mid_ex_mem_flush", 32'(ex_mem_flush), 32'd0);
    check_eq("rst_mid_md_busy", 32'(md_busy), 32'd0);
    check_eq("rst_mid_stall_cycles", stall_cycles, 32'd0);
    tick();
    rst_n = 1'b1;
    ex_md_valid = 1'b0;
    tick();
    check_eq("rst_after_pc_stop", 32'(s_pc_stop), 32'd0);
    check_eq("rst_after_md_busy", 32'(s_md_busy), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      id_rs1_used = 1'($urandom_range(0, 1));
      id_rs2_used = 1'($urandom_range(0, 1));
      ex_mem_read = ($urandom_range(0, 2) == 0);
      ex_md_valid = ($urandom_range(0, 9) == 0);
      ex_redirect = ($urandom_range(0, 6) == 0);
      dmem_wait   = ($urandom_range(0, 4) == 0);
      perf_clr    = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 199) == 0) begin
        rst_n   = 1'b0;
        m_age   = -1;
        m_stall = 32'd0;
      end else begin
        rst_n = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
